rc4_key_search_sequencer: RTL and testbench
===========================================

// Module: rc4_key_search_sequencer
// PURPOSE
//  Top-level scheduler for the RC4 key search. Per candidate key, drives ramcontroller through
//  INIT -> SHUFFLE -> DECRYPT, then advances key until a plaintext passes checker or range ends.
//  Owns ramcontroller mode/start/key inputs; ramcontroller keeps sole ownership of S-RAM ports.
// PARAMETERS
//  KEY_MIN   22'h000000  first candidate key (key[21:0]); key[23:22] always driven 0
//  KEY_MAX   22'h3FFFFF  last candidate key, inclusive; KEY_MAX >= KEY_MIN required
//  GAP       4           idle cycles with ctrl_start=0 between phases (mode changes only here)
//  TIMEOUT   20'd100000  max cycles per phase awaiting ctrl_finished; 0 disables watchdog
// PORTS
//  clk            in   1   system clock, all logic posedge
//  reset          in   1   synchronous, active-high
//  start          in   1   level; rising edge (sampled in IDLE/DONE) begins a search
//  abort          in   1   level; forces return to IDLE next cycle
//  ctrl_mode      out  3   3'b001 INIT, 3'b010 SHUFFLE, 3'b100 DECRYPT, 3'b000 none
//  ctrl_start     out  1   level start to ramcontroller, held high for whole phase
//  ctrl_key       out  24  {2'b00, cur_key[21:0]} to ramcontroller
//  ctrl_finished  in   1   ramcontroller phase complete (level, may stay high until start drops)
//  dec_fail       in   1   checker: decrypted byte out of range (valid only in DECRYPT)
//  busy           out  1   high from search accept until DONE/IDLE
//  done           out  1   high in DONE until next start or reset
//  found          out  1   valid with done: 1 = key found, 0 = range exhausted or error
//  found_key      out  24  key that passed; 24'h0 unless found
//  error          out  1   sticky watchdog timeout flag, cleared by reset or new start
// BEHAVIOUR
//  Reset: state IDLE; ctrl_mode=0, ctrl_start=0, ctrl_key=0, busy=0, done=0, found=0,
//   found_key=0, error=0, gap/watchdog counters 0. Reset has priority over abort and start.
//  States: IDLE, SETUP, RUN, GAP, NEXT, DONE. All outputs registered.
//  IDLE/DONE: on start 0->1: cur_key=KEY_MIN, phase=INIT, clear done/found/error, busy=1 -> SETUP.
//  SETUP (1 cycle): drive ctrl_mode=phase, ctrl_key; ctrl_start still 0 -> RUN.
//  RUN: ctrl_start=1, mode/key stable. Exits:
//   - ctrl_finished=1 -> ctrl_start=0 next cycle; if phase=DECRYPT and no dec_fail seen:
//     found=1, found_key=ctrl_key, -> DONE; else advance phase INIT->SHUFFLE->DECRYPT -> GAP.
//   - phase=DECRYPT & dec_fail=1 -> ctrl_start=0, -> NEXT (early reject, no wait for finished).
//   - dec_fail ignored in INIT/SHUFFLE. dec_fail and ctrl_finished same cycle = reject.
//   - watchdog reaches TIMEOUT -> error=1, ctrl_start=0, -> DONE with found=0.
//  GAP: ctrl_start=0, ctrl_mode held; counts GAP cycles AND requires ctrl_finished=0 before
//   SETUP. If ctrl_finished stays high, wait indefinitely (watchdog also runs here).
//  NEXT: if cur_key==KEY_MAX -> DONE, found=0 (no wrap). Else cur_key+1, phase=INIT -> GAP.
//  DONE: busy=0, done=1, ctrl_mode=0, ctrl_start=0; holds results until new start edge.
//  abort in any non-IDLE state: ctrl_start=0, ctrl_mode=0, busy=0, done=0, -> IDLE next cycle;
//   found/found_key/error cleared. start held high through abort does not restart (edge only).
//  Watchdog: clears on each SETUP entry; counts in RUN and GAP; saturates, never wraps.
//  Key counter 22-bit; compare to KEY_MAX before increment so KEY_MAX=22'h3FFFFF never wraps.
//  Mode change only while ctrl_start=0; ctrl_start never high in same cycle mode changes.
// TESTING
//  1 Reset 15 cycles, check all outputs 0; start=1 with ctrl_finished=0 -> SETUP then ctrl_start=1,
//    ctrl_mode=3'b001, ctrl_key=0 within 2 cycles.
//  2 Model finishes each phase after 10 cycles, dec_fail never: expect mode 001->010->100, >=GAP
//    low-start cycles between each, then done=1, found=1, found_key=24'h000000.
//  3 KEY_MIN=0,KEY_MAX=3, dec_fail pulses in DECRYPT except key 2: found_key=24'h000002, key 3 never run.
//  4 KEY_MIN=KEY_MAX=22'h3FFFFF, dec_fail always: done=1, found=0, ctrl_key never shows 0 (no wrap).
//  5 TIMEOUT=50, ctrl_finished tied 0: error=1, done=1, found=0 at ~52 cycles; new start clears error.
//  6 abort mid-SHUFFLE -> IDLE next cycle, ctrl_start=0; ctrl_finished held high in GAP stalls SETUP.

Source files
------------

// File: rtl/rc4_key_search_sequencer_if.sv
// Control bundle between the key-search sequencer and its environment.
// The sequencer drives the ramcontroller controls and the search status. The environment drives start/abort and returns the phase/checker results.
interface rc4_key_search_sequencer_if;
  logic        start;
  logic        abort;
  logic [2:0]  ctrl_mode;
  logic        ctrl_start;
  logic [23:0] ctrl_key;
  logic        ctrl_finished;
  logic        dec_fail;
  logic        busy;
  logic        done;
  logic        found;
  logic [23:0] found_key;
  logic        error;

  modport master (
    input  start, abort, ctrl_finished, dec_fail,
    output ctrl_mode, ctrl_start, ctrl_key, busy, done, found, found_key, error
  );

  modport slave (
    output start, abort, ctrl_finished, dec_fail,
    input  ctrl_mode, ctrl_start, ctrl_key, busy, done, found, found_key, error
  );
endinterface

// File: rtl/rc4_key_search_sequencer.sv
// Walks candidate keys through INIT -> SHUFFLE -> DECRYPT on the ramcontroller.
// It stops on the first key whose plaintext passes the checker, or when the key range runs out, or when the watchdog trips.
// Handshake: ctrl_start is a level held for a whole phase; ctrl_finished is a level that may stay high until ctrl_start drops. A phase is only relaunched after ctrl_finished has been seen low.
module rc4_key_search_sequencer #(
  parameter logic [21:0] KEY_MIN = 22'h000000,
  parameter logic [21:0] KEY_MAX = 22'h3FFFFF,
  parameter int unsigned GAP     = 4,
  parameter logic [19:0] TIMEOUT = 20'd100000
) (
  input  logic                              clk,
  input  logic                              reset,
  rc4_key_search_sequencer_if.master        seq_if,
  output logic [2:0]                        state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_GAP   = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] MODE_NONE = 3'b000;
  localparam logic [2:0] MODE_INIT = 3'b001;
  localparam logic [2:0] MODE_SHUF = 3'b010;
  localparam logic [2:0] MODE_DEC  = 3'b100;
  localparam logic [7:0] GAP_LAST  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [21:0] key_q, key_d;
  logic [7:0]  gap_q, gap_d;
  logic [19:0] wd_q, wd_d;
  logic        start_prev_q;
  logic [2:0]  mode_q, mode_d;
  logic        cstart_q, cstart_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        found_q, found_d;
  logic [23:0] fkey_q, fkey_d;
  logic        error_q, error_d;

  logic        start_rise;
  logic [19:0] wd_inc;
  logic        wd_hit;

  assign start_rise = seq_if.start & ~start_prev_q;
  assign wd_inc     = (wd_q == '1) ? wd_q : wd_q + 20'd1;
  assign wd_hit     = (TIMEOUT != 20'd0) && (wd_q >= TIMEOUT);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    key_d    = key_q;
    gap_d    = gap_q;
    wd_d     = wd_q;
    mode_d   = mode_q;
    cstart_d = cstart_q;
    busy_d   = busy_q;
    done_d   = done_q;
    found_d  = found_q;
    fkey_d   = fkey_q;
    error_d  = error_q;

    if (state_q != S_IDLE && seq_if.abort) begin
      state_d  = S_IDLE;
      cstart_d = 1'b0;
      mode_d   = MODE_NONE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      found_d  = 1'b0;
      fkey_d   = 24'h0;
      error_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_rise) begin
            state_d = S_SETUP;
            key_d   = KEY_MIN;
            phase_d = MODE_INIT;
            mode_d  = MODE_INIT;
            gap_d   = 8'd0;
            wd_d    = 20'd0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            found_d = 1'b0;
            fkey_d  = 24'h0;
            error_d = 1'b0;
          end
        end
        S_SETUP: begin
          state_d  = S_RUN;
          cstart_d = 1'b1;
        end
        S_RUN: begin
          wd_d = wd_inc;
          // A checker reject wins over a same-cycle finish.
          if (phase_q == MODE_DEC && seq_if.dec_fail) begin
            cstart_d = 1'b0;
            state_d  = S_NEXT;
          end else if (seq_if.ctrl_finished) begin
            cstart_d = 1'b0;
            if (phase_q == MODE_DEC) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              mode_d  = MODE_NONE;
              found_d = 1'b1;
              fkey_d  = {2'b00, key_q};
            end else begin
              phase_d = (phase_q == MODE_INIT) ? MODE_SHUF : MODE_DEC;
              gap_d   = 8'd0;
              state_d = S_GAP;
            end
          end else if (wd_hit) begin
            cstart_d = 1'b0;
            error_d  = 1'b1;
            state_d  = S_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            mode_d   = MODE_NONE;
          end
        end
        S_GAP: begin
          wd_d = wd_inc;
          if (wd_hit) begin
            error_d = 1'b1;
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            mode_d  = MODE_NONE;
          end else begin
            if (gap_q < GAP_LAST) gap_d = gap_q + 8'd1;
            // The new mode is only presented once the previous finish has cleared.
            if (gap_q >= GAP_LAST && !seq_if.ctrl_finished) begin
              state_d = S_SETUP;
              mode_d  = phase_q;
              wd_d    = 20'd0;
            end
          end
        end
        S_NEXT: begin
          if (key_q == KEY_MAX) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            mode_d  = MODE_NONE;
            found_d = 1'b0;
          end else begin
            key_d   = key_q + 22'd1;
            phase_d = MODE_INIT;
            gap_d   = 8'd0;
            state_d = S_GAP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= MODE_NONE;
      key_q        <= 22'h0;
      gap_q        <= 8'd0;
      wd_q         <= 20'd0;
      start_prev_q <= 1'b0;
      mode_q       <= MODE_NONE;
      cstart_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      fkey_q       <= 24'h0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      key_q        <= key_d;
      gap_q        <= gap_d;
      wd_q         <= wd_d;
      start_prev_q <= seq_if.start;
      mode_q       <= mode_d;
      cstart_q     <= cstart_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
      fkey_q       <= fkey_d;
      error_q      <= error_d;
    end
  end

  assign seq_if.ctrl_mode  = mode_q;
  assign seq_if.ctrl_start = cstart_q;
  assign seq_if.ctrl_key   = {2'b00, key_q};
  assign seq_if.busy       = busy_q;
  assign seq_if.done       = done_q;
  assign seq_if.found      = found_q;
  assign seq_if.found_key  = fkey_q;
  assign seq_if.error      = error_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_rc4_key_search_sequencer.sv
// Bench for the RC4 key-search sequencer: two parameterisations, behavioural ramcontroller/checker models and a result scoreboard.
module tb_rc4_key_search_sequencer;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rc4_key_search_sequencer_if a_if ();
  rc4_key_search_sequencer_if b_if ();
  logic [2:0] a_state, b_state;

  rc4_key_search_sequencer #(
    .KEY_MIN(22'h000000), .KEY_MAX(22'h000003), .GAP(4), .TIMEOUT(20'd50)
  ) dut_a (.clk(clk), .reset(reset), .seq_if(a_if), .state_o(a_state));

  rc4_key_search_sequencer #(
    .KEY_MIN(22'h3FFFFF), .KEY_MAX(22'h3FFFFF), .GAP(4), .TIMEOUT(20'd0)
  ) dut_b (.clk(clk), .reset(reset), .seq_if(b_if), .state_o(b_state));

  int checks = 0;
  int errors = 0;

  logic [25:0] exp_a_q[$];
  logic [25:0] exp_b_q[$];
  logic [2:0]  mode_log[$];
  int          low_log[$];

  logic        ma_fin_en = 1'b1;
  logic        ma_fin_force = 1'b0;
  logic        ma_fail_en = 1'b0;
  logic [23:0] ma_good_key = 24'hFFFFFF;
  int          ma_cnt = 0;
  int          mb_cnt = 0;

  logic        saw_key3 = 1'b0;
  logic        zero_seen = 1'b0;
  int          mode_viol = 0;
  logic        a_done_prev = 1'b0, b_done_prev = 1'b0, a_cs_prev = 1'b0;
  logic [2:0]  a_mode_prev = 3'b000;
  int          low_cnt = 0;
  logic [25:0] exp_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done_a(input int bound, input string name);
    int n = 0;
    while (!a_if.done && n < bound) begin cyc(1); n++; end
    check({name, "_done_in_time"}, 64'(a_if.done), 64'd1);
  endtask

  // ramcontroller + checker model for dut_a
  initial begin
    a_if.ctrl_finished = 1'b0;
    a_if.dec_fail      = 1'b0;
    forever begin
      @(negedge clk);
      if (a_if.ctrl_start === 1'b1) ma_cnt++; else ma_cnt = 0;
      a_if.ctrl_finished = ma_fin_force || (ma_fin_en && a_if.ctrl_start === 1'b1 && ma_cnt >= 10);
      a_if.dec_fail = ma_fail_en && a_if.ctrl_start === 1'b1 && a_if.ctrl_mode == 3'b100 &&
                      ma_cnt == 3 && a_if.ctrl_key != ma_good_key;
    end
  end

  // dut_b model: checker rejects every plaintext
  initial begin
    b_if.ctrl_finished = 1'b0;
    b_if.dec_fail      = 1'b1;
    forever begin
      @(negedge clk);
      if (b_if.ctrl_start === 1'b1) mb_cnt++; else mb_cnt = 0;
      b_if.ctrl_finished = (b_if.ctrl_start === 1'b1) && mb_cnt >= 10;
    end
  end

  // monitor / scoreboard for dut_a
  initial begin
    forever begin
      @(negedge clk);
      if (a_if.ctrl_start === 1'b1 && a_if.ctrl_key == 24'h3) saw_key3 = 1'b1;
      if (a_if.ctrl_start === 1'b1 && a_if.ctrl_mode != a_mode_prev) mode_viol++;
      if (a_if.ctrl_start === 1'b1 && !a_cs_prev) begin
        mode_log.push_back(a_if.ctrl_mode);
        low_log.push_back(low_cnt);
        low_cnt = 0;
      end else if (a_if.ctrl_start === 1'b0) begin
        low_cnt++;
      end
      if (a_if.done === 1'b1 && !a_done_prev) begin
        check("a_result_expected", 64'(exp_a_q.size() > 0), 64'd1);
        if (exp_a_q.size() > 0) begin
          exp_v = exp_a_q.pop_front();
          check("a_result", 64'({a_if.found, a_if.found_key, a_if.error}), 64'(exp_v));
        end
      end
      a_done_prev = (a_if.done === 1'b1);
      a_cs_prev   = (a_if.ctrl_start === 1'b1);
      a_mode_prev = a_if.ctrl_mode;
    end
  end

  // monitor / scoreboard for dut_b
  initial begin
    forever begin
      @(negedge clk);
      if (b_if.busy === 1'b1 && b_if.ctrl_key == 24'h0) zero_seen = 1'b1;
      if (b_if.done === 1'b1 && !b_done_prev) begin
        check("b_result_expected", 64'(exp_b_q.size() > 0), 64'd1);
        if (exp_b_q.size() > 0) begin
          exp_v = exp_b_q.pop_front();
          check("b_result", 64'({b_if.found, b_if.found_key, b_if.error}), 64'(exp_v));
        end
      end
      b_done_prev = (b_if.done === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    reset = 1'b1;
    a_if.start = 1'b0; a_if.abort = 1'b0;
    b_if.start = 1'b0; b_if.abort = 1'b0;
    cyc(15);
    check("reset_a", 64'({a_state, a_if.ctrl_mode, a_if.ctrl_start, a_if.ctrl_key, a_if.busy,
                          a_if.done, a_if.found, a_if.found_key, a_if.error}), 64'd0);
    check("reset_b", 64'({b_state, b_if.ctrl_mode, b_if.ctrl_start, b_if.ctrl_key, b_if.busy,
                          b_if.done, b_if.found, b_if.found_key, b_if.error}), 64'd0);
    reset = 1'b0;
    cyc(1);

    // first key passes, no rejections
    mode_log.delete(); low_log.delete();
    exp_a_q.push_back({1'b1, 24'h000000, 1'b0});
    a_if.start = 1'b1;
    cyc(1);
    check("t1_setup", 64'({a_state, a_if.ctrl_start, a_if.ctrl_mode, a_if.ctrl_key, a_if.busy}),
          64'({ST_SETUP, 1'b0, 3'b001, 24'h0, 1'b1}));
    cyc(1);
    check("t1_run", 64'({a_if.ctrl_start, a_if.ctrl_mode, a_if.ctrl_key}), 64'({1'b1, 3'b001, 24'h0}));
    a_if.start = 1'b0;
    wait_done_a(400, "t2");
    check("t2_mode_count", 64'(mode_log.size()), 64'd3);
    if (mode_log.size() == 3)
      check("t2_mode_seq", 64'({mode_log[0], mode_log[1], mode_log[2]}), 64'(9'b001_010_100));
    if (low_log.size() == 3)
      check("t2_gap_low", 64'(low_log[1] >= 4 && low_log[2] >= 4), 64'd1);
    cyc(5);
    check("t2_hold", 64'({a_if.busy, a_if.done, a_if.found, a_if.ctrl_mode, a_if.ctrl_start}),
          64'({1'b0, 1'b1, 1'b1, 3'b000, 1'b0}));

    // keys 0,1 rejected in DECRYPT, key 2 passes, key 3 never launched
    mode_log.delete(); low_log.delete();
    ma_fail_en = 1'b1; ma_good_key = 24'h000002; saw_key3 = 1'b0;
    exp_a_q.push_back({1'b1, 24'h000002, 1'b0});
    a_if.start = 1'b1; cyc(1); a_if.start = 1'b0;
    wait_done_a(1000, "t3");
    check("t3_key3_unused", 64'(saw_key3), 64'd0);
    check("t3_phase_count", 64'(mode_log.size()), 64'd9);

    // every key rejected: range exhausted after KEY_MAX
    mode_log.delete(); low_log.delete();
    ma_good_key = 24'hFFFFFF;
    exp_a_q.push_back({1'b0, 24'h000000, 1'b0});
    a_if.start = 1'b1; cyc(1); a_if.start = 1'b0;
    wait_done_a(1000, "t3x");
    check("t3x_phase_count", 64'(mode_log.size()), 64'd12);
    ma_fail_en = 1'b0;

    // watchdog: ramcontroller never finishes
    ma_fin_en = 1'b0;
    exp_a_q.push_back({1'b0, 24'h000000, 1'b1});
    a_if.start = 1'b1; cyc(1); a_if.start = 1'b0;
    n = 1;
    while (!a_if.done && n < 200) begin cyc(1); n++; end
    check("t5_done_in_time", 64'(a_if.done), 64'd1);
    check("t5_latency_window", 64'(n >= 48 && n <= 58), 64'd1);
    a_if.start = 1'b1; cyc(1);
    check("t5_error_cleared", 64'({a_if.error, a_if.done, a_state}), 64'({1'b0, 1'b0, ST_SETUP}));
    a_if.start = 1'b0; a_if.abort = 1'b1; cyc(1); a_if.abort = 1'b0;
    check("t5_abort_idle", 64'({a_state, a_if.busy}), 64'({ST_IDLE, 1'b0}));
    ma_fin_en = 1'b1;

    // abort during SHUFFLE with start held high
    cyc(1);
    a_if.start = 1'b1;
    n = 0;
    while (!(a_if.ctrl_start && a_if.ctrl_mode == 3'b010) && n < 100) begin cyc(1); n++; end
    check("t6_reach_shuffle", 64'({a_if.ctrl_start, a_if.ctrl_mode}), 64'({1'b1, 3'b010}));
    cyc(3);
    a_if.abort = 1'b1; cyc(1);
    check("t6_abort", 64'({a_state, a_if.ctrl_start, a_if.ctrl_mode, a_if.busy, a_if.done, a_if.found, a_if.error}),
          64'({ST_IDLE, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0}));
    a_if.abort = 1'b0; cyc(3);
    check("t6_no_restart", 64'({a_state, a_if.busy}), 64'({ST_IDLE, 1'b0}));
    a_if.start = 1'b0; cyc(1);

    // ctrl_finished held high in GAP keeps SETUP from starting
    a_if.start = 1'b1; cyc(1); a_if.start = 1'b0;
    n = 0;
    while (a_state != ST_GAP && n < 100) begin cyc(1); n++; end
    check("t6_reach_gap", 64'(a_state), 64'(ST_GAP));
    ma_fin_force = 1'b1;
    cyc(20);
    check("t6_gap_stall", 64'({a_state, a_if.ctrl_start, a_if.ctrl_mode}), 64'({ST_GAP, 1'b0, 3'b001}));
    ma_fin_force = 1'b0;
    n = 0;
    while (!a_if.ctrl_start && n < 20) begin cyc(1); n++; end
    check("t6_resume", 64'({a_if.ctrl_start, a_if.ctrl_mode}), 64'({1'b1, 3'b010}));
    a_if.abort = 1'b1; cyc(1); a_if.abort = 1'b0;
    check("t6_final_abort", 64'({a_state, a_if.ctrl_start}), 64'({ST_IDLE, 1'b0}));

    // single top-of-range key, always rejected
    zero_seen = 1'b0;
    exp_b_q.push_back({1'b0, 24'h000000, 1'b0});
    b_if.start = 1'b1; cyc(1); b_if.start = 1'b0;
    n = 0;
    while (!b_if.done && n < 300) begin cyc(1); n++; end
    check("t4_done_in_time", 64'(b_if.done), 64'd1);
    check("t4_key_no_wrap", 64'(b_if.ctrl_key), 64'h3FFFFF);
    check("t4_zero_key_unseen", 64'(zero_seen), 64'd0);

    cyc(3);
    check("a_queue_drained", 64'(exp_a_q.size()), 64'd0);
    check("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
    check("mode_change_with_start", 64'(mode_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
